// File: rtl/calc_pkg.sv
// Shared opcodes, command record and sizing constants for the calculator command sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_ADD  = 2'd2,
    OP_MUL  = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ISSUE  = 2'd2,
    S_REJECT = 2'd3
  } seq_state_e;

  typedef struct packed {
    calc_op_e   op;
    logic [7:0] data;
  } calc_cmd_t;

  localparam int FIFO_DEPTH    = 4;
  localparam int STACK_MAX     = 8;
  localparam int TURBO_LOCKOUT = 4;

endpackage

// File: rtl/calc_btn_conditioner.sv
// One pushbutton: 2-flop synchroniser, rising-edge detect, then a down-counting
// re-trigger lockout. Emits a registered one-cycle pulse per accepted press.
module calc_btn_conditioner
  import calc_pkg::*;
#(
  parameter int LOCKOUT_SLOW = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic turbo_i,
  output logic pulse_o
);

  logic             sync1_q, sync2_q, prev_q, pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;
  logic             accept;

  assign rise   = sync2_q & ~prev_q;
  assign accept = rise && (cnt_q == '0);

  // Edges seen while the counter is non-zero are dropped without restarting it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = turbo_i ? CNT_W'(TURBO_LOCKOUT) : CNT_W'(LOCKOUT_SLOW);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= accept;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Turns four conditioned buttons into a queued command stream for the stack CPU,
// refusing commands that would over/underflow the tracked stack depth.
// state  | meaning
// IDLE   | wait for a queued command, pop head into the output register
// CHECK  | test the held command against the tracked depth
// ISSUE  | offer the command, hold until CmdReady
// REJECT | one-cycle ErrStack pulse, command dropped
module calc_cmd_sequencer #(
  parameter int FIFO_DEPTH   = calc_pkg::FIFO_DEPTH,
  parameter int STACK_MAX    = calc_pkg::STACK_MAX,
  parameter int LOCKOUT_SLOW = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Din,
  input  logic       Sample,
  input  logic [2:0] Btns,
  input  logic       Turbo,
  output logic       CmdValid,
  output logic [1:0] CmdOp,
  output logic [7:0] CmdData,
  input  logic       CmdReady,
  output logic [3:0] Depth,
  output logic       ErrFull,
  output logic       ErrStack
);

  localparam int CNT_W = ($clog2(LOCKOUT_SLOW + 1) > 3) ? $clog2(LOCKOUT_SLOW + 1) : 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]     DEPTH_MAX = 4'(STACK_MAX);

  logic [3:0] btn_raw, btn_pulse;
  assign btn_raw = {Sample, Btns};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    calc_btn_conditioner #(
      .LOCKOUT_SLOW (LOCKOUT_SLOW),
      .CNT_W        (CNT_W)
    ) u_cond (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .btn_i   (btn_raw[g]),
      .turbo_i (Turbo),
      .pulse_o (btn_pulse[g])
    );
  end

  calc_pkg::calc_cmd_t enq_cmd;
  logic                enq;

  // Bit 3 is Push, so scanning downward gives Push > Pop > Add > Mult.
  always_comb begin
    enq          = 1'b1;
    enq_cmd.op   = calc_pkg::OP_PUSH;
    enq_cmd.data = Din;
    if (btn_pulse[3]) begin
      enq_cmd.op = calc_pkg::OP_PUSH;
    end else if (btn_pulse[2]) begin
      enq_cmd.op   = calc_pkg::OP_POP;
      enq_cmd.data = 8'd0;
    end else if (btn_pulse[1]) begin
      enq_cmd.op   = calc_pkg::OP_ADD;
      enq_cmd.data = 8'd0;
    end else if (btn_pulse[0]) begin
      enq_cmd.op   = calc_pkg::OP_MUL;
      enq_cmd.data = 8'd0;
    end else begin
      enq = 1'b0;
    end
  end

  calc_pkg::calc_cmd_t mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                deq, full, wr_ok, err_full_q;

  assign full  = (count_q == CNT_FULL);
  assign wr_ok = enq && (!full || deq);

  always_ff @(posedge Clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= enq_cmd;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_full_q <= 1'b0;
    end else begin
      err_full_q <= enq && full && !deq;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_ok && !deq)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (!wr_ok && deq) count_q <= count_q - (PTR_W + 1)'(1);
    end
  end

  calc_pkg::seq_state_e state_q, state_d;
  calc_pkg::calc_op_e   op_q, op_d;
  logic [7:0]           data_q, data_d;
  logic [3:0]           depth_q, depth_d;
  logic                 legal, cmd_valid, err_stack;

  always_comb begin
    case (op_q)
      calc_pkg::OP_PUSH: legal = (depth_q < DEPTH_MAX);
      calc_pkg::OP_POP:  legal = (depth_q >= 4'd1);
      default:           legal = (depth_q >= 4'd2);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    depth_d   = depth_q;
    deq       = 1'b0;
    cmd_valid = 1'b0;
    err_stack = 1'b0;
    case (state_q)
      calc_pkg::S_IDLE: begin
        if (count_q != '0) begin
          deq     = 1'b1;
          op_d    = mem_q[rd_ptr_q].op;
          data_d  = mem_q[rd_ptr_q].data;
          state_d = calc_pkg::S_CHECK;
        end
      end
      calc_pkg::S_CHECK: state_d = legal ? calc_pkg::S_ISSUE : calc_pkg::S_REJECT;
      calc_pkg::S_ISSUE: begin
        cmd_valid = 1'b1;
        if (CmdReady) begin
          state_d = calc_pkg::S_IDLE;
          depth_d = (op_q == calc_pkg::OP_PUSH) ? depth_q + 4'd1 : depth_q - 4'd1;
        end
      end
      calc_pkg::S_REJECT: begin
        err_stack = 1'b1;
        state_d   = calc_pkg::S_IDLE;
      end
      default: state_d = calc_pkg::S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= calc_pkg::S_IDLE;
      op_q    <= calc_pkg::OP_PUSH;
      data_q  <= 8'd0;
      depth_q <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      depth_q <= depth_d;
    end
  end

  assign CmdValid = cmd_valid;
  assign CmdOp    = op_q;
  assign CmdData  = data_q;
  assign Depth    = depth_q;
  assign ErrFull  = err_full_q;
  assign ErrStack = err_stack;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer: vector table, directed corner cases,
// and random presses scored against a stack-depth reference model.
module tb_calc_cmd_sequencer;

  logic       Clk = 1'b0, Reset = 1'b1, Sample = 1'b0, Turbo = 1'b1, CmdReady = 1'b1;
  logic [7:0] Din = 8'd0;
  logic [2:0] Btns = 3'd0;
  logic       CmdValid, ErrFull, ErrStack;
  logic [1:0] CmdOp;
  logic [7:0] CmdData;
  logic [3:0] Depth;

  int         n_checks = 0, n_fail = 0;
  int         n_full = 0, n_stack = 0;
  logic [9:0] hs_q[$];
  logic       rand_ready = 1'b0;

  calc_cmd_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Sample(Sample), .Btns(Btns), .Turbo(Turbo),
    .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdData(CmdData), .CmdReady(CmdReady),
    .Depth(Depth), .ErrFull(ErrFull), .ErrStack(ErrStack)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (CmdValid && CmdReady) hs_q.push_back({CmdOp, CmdData});
      if (ErrFull)  n_full++;
      if (ErrStack) n_stack++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (rand_ready) CmdReady = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Sample = 1'b0; Btns = 3'd0; CmdReady = 1'b1; rand_ready = 1'b0;
    tick(2);
    check("outs_in_reset", {CmdValid, CmdOp, CmdData, Depth, ErrFull, ErrStack}, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("outs_after_reset", {CmdValid, CmdOp, CmdData, Depth, ErrFull, ErrStack}, 0);
    n_full = 0; n_stack = 0; hs_q.delete();
    @(posedge Clk); #1;
  endtask

  // sel: 0=Push 1=Pop 2=Add 3=Mult
  task automatic press(input int sel, input logic [7:0] d);
    Din = d;
    case (sel)
      0:       Sample  = 1'b1;
      1:       Btns[2] = 1'b1;
      2:       Btns[1] = 1'b1;
      default: Btns[0] = 1'b1;
    endcase
    tick(2);
    Sample = 1'b0; Btns = 3'd0;
    tick(12);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] din;
    int         exp_hs;
    logic [1:0] exp_op;
    logic [7:0] exp_data;
    logic [3:0] exp_depth;
    int         exp_err;
  } vec_t;

  vec_t       tbl[9];
  logic [9:0] e;
  logic [9:0] exp_q[$];
  int         hs0, st0, md, exp_err, sel, sz;
  logic [7:0] d;

  initial begin
    tbl[0] = '{0, 8'd2,   1, 2'd0, 8'd2,   4'd1, 0};
    tbl[1] = '{0, 8'd5,   1, 2'd0, 8'd5,   4'd2, 0};
    tbl[2] = '{2, 8'd77,  1, 2'd2, 8'd0,   4'd1, 0};
    tbl[3] = '{3, 8'd0,   0, 2'd0, 8'd0,   4'd1, 1};
    tbl[4] = '{0, 8'h80,  1, 2'd0, 8'h80,  4'd2, 0};
    tbl[5] = '{3, 8'd9,   1, 2'd3, 8'd0,   4'd1, 0};
    tbl[6] = '{1, 8'd0,   1, 2'd1, 8'd0,   4'd0, 0};
    tbl[7] = '{1, 8'd0,   0, 2'd0, 8'd0,   4'd0, 1};
    tbl[8] = '{2, 8'd0,   0, 2'd0, 8'd0,   4'd0, 1};

    // Vector table: Push 2, Push 5, Add, then boundary legality cases
    do_reset();
    for (int i = 0; i < 9; i++) begin
      hs0 = hs_q.size(); st0 = n_stack;
      press(tbl[i].sel, tbl[i].din);
      check($sformatf("tbl%0d_hs_count", i), hs_q.size() - hs0, tbl[i].exp_hs);
      if (tbl[i].exp_hs != 0 && hs_q.size() > 0) begin
        e = hs_q[hs_q.size() - 1];
        check($sformatf("tbl%0d_op_data", i), e, {tbl[i].exp_op, tbl[i].exp_data});
      end
      check($sformatf("tbl%0d_depth", i), Depth, tbl[i].exp_depth);
      check($sformatf("tbl%0d_errstack", i), n_stack - st0, tbl[i].exp_err);
    end
    check("tbl_errfull", n_full, 0);

    // Pop on empty stack
    do_reset();
    press(1, 8'd0);
    check("pop_empty_errstack", n_stack, 1);
    check("pop_empty_no_cmd", hs_q.size(), 0);
    check("pop_empty_depth", Depth, 0);

    // Latency and hold while not ready
    do_reset();
    CmdReady = 1'b0;
    Din = 8'hFD; Sample = 1'b1;
    @(posedge Clk);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("lat_valid_cycle4", CmdValid, 0);
    @(posedge Clk);
    @(negedge Clk);
    check("lat_valid_cycle5", {CmdValid, CmdOp, CmdData}, {1'b1, 2'd0, 8'hFD});
    Sample = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check($sformatf("hold_c%0d", i), {CmdValid, CmdOp, CmdData}, {1'b1, 2'd0, 8'hFD});
    end
    @(posedge Clk); #1;
    CmdReady = 1'b1;
    tick(3);
    check("hold_hs_count", hs_q.size(), 1);
    check("hold_depth", Depth, 1);

    // Queue full with CPU stalled
    do_reset();
    press(0, 8'd3);
    press(0, 8'd4);
    CmdReady = 1'b0;
    for (int i = 0; i < 6; i++) press(3, 8'd0);
    check("full_errfull", n_full, 1);
    check("full_held_mul", {CmdValid, CmdOp}, {1'b1, 2'd3});
    check("full_hs_count", hs_q.size(), 2);
    CmdReady = 1'b1;
    tick(30);
    check("full_drain_hs", hs_q.size(), 3);
    check("full_drain_errstack", n_stack, 4);
    check("full_drain_depth", Depth, 1);

    // Simultaneous Push and Mult
    do_reset();
    Din = 8'd11; Sample = 1'b1; Btns[0] = 1'b1;
    tick(2);
    Sample = 1'b0; Btns = 3'd0;
    tick(12);
    check("simul_hs_count", hs_q.size(), 1);
    if (hs_q.size() > 0) check("simul_op_data", hs_q[0], {2'd0, 8'd11});
    check("simul_errstack", n_stack, 0);

    // Nine pushes against an 8-deep stack
    do_reset();
    for (int i = 0; i < 9; i++) press(0, 8'(i + 1));
    check("ovf_hs_count", hs_q.size(), 8);
    check("ovf_errstack", n_stack, 1);
    check("ovf_depth", Depth, 8);
    check("ovf_errfull", n_full, 0);

    // Turbo lockout: second Pop edge two cycles later is ignored
    do_reset();
    press(0, 8'd7);
    Btns[2] = 1'b1; tick(1);
    Btns = 3'd0;    tick(1);
    Btns[2] = 1'b1; tick(1);
    Btns = 3'd0;    tick(15);
    check("lockout_hs_count", hs_q.size(), 2);
    check("lockout_errstack", n_stack, 0);
    check("lockout_depth", Depth, 0);

    // Reset while a command is held in ISSUE
    press(0, 8'd7);
    CmdReady = 1'b0;
    press(0, 8'd9);
    check("abort_pre_valid", {CmdValid, CmdData, Depth}, {1'b1, 8'd9, 4'd1});
    hs0 = hs_q.size();
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort_valid_depth", {CmdValid, Depth}, 0);
    Reset = 1'b0; CmdReady = 1'b1;
    tick(15);
    check("abort_no_reissue", hs_q.size() - hs0, 0);
    check("abort_idle", {CmdValid, Depth}, 0);

    // Random presses against a depth-tracking model
    do_reset();
    rand_ready = 1'b1;
    md = 0; exp_err = 0; exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      sel = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 3));
      d   = 8'($urandom);
      case (sel)
        0: if (md < 8)  begin exp_q.push_back({2'd0, d});    md = md + 1; end else exp_err++;
        1: if (md >= 1) begin exp_q.push_back({2'd1, 8'd0}); md = md - 1; end else exp_err++;
        2: if (md >= 2) begin exp_q.push_back({2'd2, 8'd0}); md = md - 1; end else exp_err++;
        default: if (md >= 2) begin exp_q.push_back({2'd3, 8'd0}); md = md - 1; end else exp_err++;
      endcase
      press(sel, d);
    end
    rand_ready = 1'b0; CmdReady = 1'b1;
    tick(20);
    check("rand_hs_count", hs_q.size(), exp_q.size());
    sz = (hs_q.size() < exp_q.size()) ? hs_q.size() : exp_q.size();
    for (int i = 0; i < sz; i++) check($sformatf("rand_cmd%0d", i), hs_q[i], exp_q[i]);
    check("rand_errstack", n_stack, exp_err);
    check("rand_depth", Depth, md);
    check("rand_errfull", n_full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
